// File: rtl/iob_countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default widths.
package iob_countdown_timer_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int PRESC_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/iob_prescaler.sv
// Prescaler: counts enabled clocks and fires a one-cycle tick every presc_i+1 of them.
module iob_prescaler
  import iob_countdown_timer_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_cnt;

  // >= rather than == so that lowering presc_i below the current count fires at once
  assign tick_o = en_i && (presc_cnt >= presc_i);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      presc_cnt <= '0;
    end else if (clr_i) begin
      presc_cnt <= '0;
    end else if (en_i) begin
      presc_cnt <= tick_o ? '0 : presc_cnt + ONE;
    end
  end

endmodule

// File: rtl/iob_countdown_timer.sv
// Loadable down-counting timer with prescaler, one-shot or periodic reload, sticky done flag.
module iob_countdown_timer
  import iob_countdown_timer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int RST_VAL = 0
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [DATA_W-1:0]  load_val_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               periodic_i,
  input  logic               clr_done_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               tc_o,
  output logic               done_o,
  output logic               busy_o
);

  localparam logic [DATA_W-1:0] RST_D = DATA_W'(RST_VAL);
  localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);

  state_e             state, state_d;
  logic [DATA_W-1:0]  reload, reload_d, data_d;
  logic               tc_d, done_d;
  logic               presc_clr, presc_en, tick;

  iob_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clr_i    (presc_clr),
    .en_i     (presc_en),
    .presc_i  (presc_i),
    .tick_o   (tick)
  );

  // NOTE: every output of this block gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    data_d    = data_o;
    reload_d  = reload;
    tc_d      = 1'b0;
    presc_clr = 1'b0;
    presc_en  = 1'b0;

    if (rst_i) begin
      state_d   = ST_IDLE;
      data_d    = RST_D;
      reload_d  = RST_D;
      presc_clr = 1'b1;
    end else if (load_i) begin
      reload_d  = load_val_i;
      data_d    = load_val_i;
      presc_clr = 1'b1;
    end else if (stop_i) begin
      if (state == ST_RUN) state_d = ST_IDLE;
    end else if (start_i && state == ST_IDLE) begin
      if (data_o == '0) begin
        state_d = ST_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (start_i && state == ST_DONE) begin
      if (reload == '0) begin
        tc_d = 1'b1;
      end else begin
        data_d    = reload;
        presc_clr = 1'b1;
        state_d   = ST_RUN;
      end
    end else if (state == ST_RUN) begin
      presc_en = 1'b1;
      if (tick) begin
        if (data_o == ONE) begin
          tc_d = 1'b1;
          if (periodic_i && reload != '0) begin
            data_d = reload;
          end else begin
            data_d  = '0;
            state_d = ST_DONE;
          end
        end else if (data_o != '0) begin
          data_d = data_o - ONE;
        end
      end
    end

    // A terminal count in the same cycle as a clear keeps the flag set
    if (rst_i)           done_d = 1'b0;
    else if (tc_d)       done_d = 1'b1;
    else if (clr_done_i) done_d = 1'b0;
    else                 done_d = done_o;
  end

  // NOTE: only the control and count registers sit on the async reset; there is no
  // memory here that would need to be left out of it.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state  <= ST_IDLE;
      reload <= RST_D;
      data_o <= RST_D;
      tc_o   <= 1'b0;
      done_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_d;
      reload <= reload_d;
      data_o <= data_d;
      tc_o   <= tc_d;
      done_o <= done_d;
      busy_o <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_iob_countdown_timer.sv
// Scoreboard bench for iob_countdown_timer: directed scenarios plus random traffic against a behavioural model.
module tb_iob_countdown_timer;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int RV = 5;

  logic          clk_i = 1'b0;
  logic          arst_n_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          load_i = 1'b0;
  logic [DW-1:0] load_val_i = '0;
  logic [PW-1:0] presc_i = '0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          periodic_i = 1'b0;
  logic          clr_done_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          tc_o, done_o, busy_o;

  iob_countdown_timer #(
    .DATA_W  (DW),
    .PRESC_W (PW),
    .RST_VAL (RV)
  ) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .rst_i      (rst_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .presc_i    (presc_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .periodic_i (periodic_i),
    .clr_done_i (clr_done_i),
    .data_o     (data_o),
    .tc_o       (tc_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          tc;
    logic          done;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural reference: the timer is paused, counting or expired; while counting,
  // one step is taken every presc+1 counting clocks.
  typedef enum {PAUSED, COUNTING, EXPIRED} mode_e;
  mode_e m_mode;
  int    m_count, m_reload, m_elapsed;
  bit    m_done;

  task automatic model_reset();
    m_mode    = PAUSED;
    m_count   = RV;
    m_reload  = RV;
    m_elapsed = 0;
    m_done    = 0;
  endtask

  task automatic model_step(input bit ld, input int val, input int pr, input bit st,
                            input bit sp, input bit per, input bit clr, input bit rs,
                            output bit tc);
    tc = 0;
    if (rs) begin
      model_reset();
    end else if (ld) begin
      m_reload  = val;
      m_count   = val;
      m_elapsed = 0;
    end else if (sp) begin
      if (m_mode == COUNTING) m_mode = PAUSED;
    end else if (st && m_mode == PAUSED) begin
      if (m_count == 0) begin
        m_mode = EXPIRED;
        tc = 1;
      end else m_mode = COUNTING;
    end else if (st && m_mode == EXPIRED) begin
      if (m_reload == 0) tc = 1;
      else begin
        m_count   = m_reload;
        m_elapsed = 0;
        m_mode    = COUNTING;
      end
    end else if (m_mode == COUNTING) begin
      if (m_elapsed < pr) m_elapsed++;
      else begin
        m_elapsed = 0;
        if (m_count == 1) begin
          tc = 1;
          if (per && m_reload != 0) m_count = m_reload;
          else begin
            m_count = 0;
            m_mode  = EXPIRED;
          end
        end else if (m_count > 0) m_count--;
      end
    end
    if (!rs) begin
      if (tc) m_done = 1;
      else if (clr) m_done = 0;
    end
  endtask

  task automatic drive(input bit ld, input int val, input int pr, input bit st,
                       input bit sp, input bit per, input bit clr, input bit rs);
    bit   tc;
    exp_t e;
    @(negedge clk_i);
    load_i     = ld;
    load_val_i = DW'(val);
    presc_i    = PW'(pr);
    start_i    = st;
    stop_i     = sp;
    periodic_i = per;
    clr_done_i = clr;
    rst_i      = rs;
    model_step(ld, val, pr, st, sp, per, clr, rs, tc);
    e.data = DW'(m_count);
    e.tc   = tc;
    e.done = m_done;
    e.busy = (m_mode == COUNTING);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input int pr, input bit per);
    for (int i = 0; i < n; i++) drive(0, 0, pr, 0, 0, per, 0, 0);
  endtask

  // Monitor: the timer presents a fresh output set every clock; compare it against
  // the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_o", 32'(data_o), 32'(e.data));
        check("tc_o",   32'(tc_o),   32'(e.tc));
        check("done_o", 32'(done_o), 32'(e.done));
        check("busy_o", 32'(busy_o), 32'(e.busy));
      end
    end
  end

  initial begin
    bit ld, st, sp, per, clr, rs;
    int pr;

    model_reset();
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_data", 32'(data_o), RV);
    check("rst_tc",   32'(tc_o),   0);
    check("rst_done", 32'(done_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    idle(3, 0, 0);

    // one-shot, presc 0: 3,2,1,0 with tc in the third clock after start
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    idle(6, 0, 0);

    // periodic with prescaler: tc every 10 clocks
    drive(0, 0, 4, 0, 0, 1, 1, 0);
    drive(1, 2, 4, 0, 0, 1, 0, 0);
    drive(0, 0, 4, 1, 0, 1, 0, 0);
    idle(32, 4, 1);
    drive(0, 0, 4, 0, 1, 1, 0, 0);

    // pause and resume
    drive(1, 10, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 3, 1, 0, 0, 0, 0);
    idle(7, 3, 0);
    drive(0, 0, 3, 0, 1, 0, 0, 0);
    idle(20, 3, 0);
    drive(0, 0, 3, 1, 0, 0, 0, 0);
    idle(45, 3, 0);

    // start at zero with a simultaneous clear: tc next cycle, done stays set, no RUN
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 1, 0);
    idle(2, 0, 0);
    // restart from DONE with reload 0 pulses tc again
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    idle(2, 0, 0);

    // reload during RUN at data 1: no tc, interval restarts
    drive(1, 3, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    idle(2, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    idle(5, 0, 0);

    // sync reset on the terminal tick: no tc, back to RST_VAL and idle
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    idle(2, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3, 0, 0);

    // random traffic
    pr  = 0;
    per = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) pr = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) per = ~per;
      rs  = ($urandom_range(0, 99) < 1);
      ld  = ($urandom_range(0, 99) < 5);
      sp  = ($urandom_range(0, 99) < 4);
      st  = ($urandom_range(0, 99) < 12);
      clr = ($urandom_range(0, 99) < 6);
      drive(ld, $urandom_range(0, 7), pr, st, sp, per, clr, rs);
    end
    idle(2, pr, per);

    @(posedge clk_i);
    #2;
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
